panel_draw_scheduler: RTL
=========================

// Module: panel_draw_scheduler
// PURPOSE
//  Sole owner of the vga_adapter plot port (x, y, colour, plot).
//  Two requesters share it: the computer panel (left, x 0..79) and the user panel (right, x 80..159).
//  Each request redraws one 80x120 panel with a 1-bit rock/scissor/paper ROM image.
//  Arbitration is round-robin; one pixel is issued per clock.
//  ROM read latency is aligned so that x, y and colour stay coherent.
// PARAMETERS
//  PANEL_W    80      panel width in pixels; user panel origin x = PANEL_W
//  PANEL_H    120     panel height in pixels
//  ROM_LAT    1       ROM clock-to-q latency in cycles; legal values 1 or 2
//  FG_COLOUR  3'b010  colour for ROM pixels with rom_q = 0
// PORTS
//  CLOCK_50  in   1   system clock; all logic on posedge
//  reset_n   in   1   reset, asynchronous, active-low
//  req_c     in   1   computer panel redraw request; level, held until ack_c
//  sel_c     in   2   computer image: 00 rock, 01 scissor, 10 paper, 11 = paper
//  req_u     in   1   user panel redraw request; level, held until ack_u
//  sel_u     in   2   user image; same encoding as sel_c
//  ack_c     out  1   1-cycle pulse: computer request granted, sel_c latched
//  ack_u     out  1   1-cycle pulse: user request granted, sel_u latched
//  busy      out  1   high from grant until the last pixel has been plotted
//  done      out  1   1-cycle pulse coincident with the last plot of a panel
//  rom_addr  out  14  panel-local ROM address = ly*PANEL_W + lx
//  rom_sel   out  2   image select for the external ROM mux (latched sel)
//  rom_q     in   1   muxed ROM data; 1 = background, 0 = foreground
//  x         out  8   framebuffer x = origin + lx, delayed ROM_LAT cycles
//  y         out  7   framebuffer y = ly, delayed ROM_LAT cycles
//  colour    out  3   pixel colour, aligned with x/y
//  plot      out  1   write strobe to vga_adapter
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; round-robin pointer favours computer; pipeline valids cleared.
//  Reset is asynchronous. Asserted mid-draw, plot drops to 0 at once and the partial draw is abandoned.
//  FSM states:
//   IDLE  -> GRANT when req_c | req_u is high.
//   GRANT -> SCAN after one cycle. Pulses ack_*, latches sel into rom_sel, sets owner, busy = 1.
//   SCAN  -> DRAIN when the address lx = PANEL_W-1, ly = PANEL_H-1 has been issued.
//   DRAIN -> IDLE when the ROM_LAT-deep pipeline is empty.
//  Arbitration:
//   - Only one requester high: that one is granted.
//   - Both high: grant the one not granted last.
//   - Tie after reset: computer wins.
//  SCAN scan order:
//   - One address per cycle; lx increments 0..PANEL_W-1.
//   - lx wraps to 0 and ly increments.
//   - No idle cycles inside a panel.
//  Datapath:
//   - Pipeline carries {valid, x, y, owner} for ROM_LAT stages.
//   - plot = valid of the last stage.
//   - Exactly PANEL_W*PANEL_H plot cycles (9600) per grant.
//   - First plot occurs ROM_LAT cycles after the first address.
//  Colour:
//   - rom_q = 0 -> FG_COLOUR.
//   - rom_q = 1, owner computer -> 3'b111; rom_q = 1, owner user -> 3'b000.
//  Address arithmetic: rom_addr is computed unsigned in 14 bits. x = {1'b0, lx} + origin in 8 bits; no overflow for legal parameters.
//  Handshake and timing:
//   - Requests arriving while busy are held by the requester and are not acked until IDLE.
//   - Deasserting req after ack does not abort the draw.
//   - Changing sel after ack has no effect on the current draw.
//   - done and busy fall together; earliest next ack is the cycle after done.
// CONFIGURATION
//  CLEAR_ON_RESET_EN defined:
//   - After reset release, FSM enters CLEAR first.
//   - CLEAR sweeps x 0..159, y 0..119 with colour 3'b000 and plot = 1 each cycle (19200 cycles).
//   - busy = 1 throughout CLEAR; no ack is issued; no done pulse is issued.
//   - After CLEAR -> IDLE.
//  CLEAR_ON_RESET_EN undefined: no CLEAR state; FSM goes straight to IDLE after reset.
// TESTING
//  1. req_c = 1, sel_c = 00, ROM pattern rom_q = addr[0]:
//     -> ack_c pulses once; 9600 plots at x 0..79, y 0..119 in raster order.
//     -> even addresses (rom_q = 0) give colour 010; odd addresses (rom_q = 1) give 111.
//     -> done pulses with the plot at (79,119).
//  2. req_u = 1, sel_u = 01, rom_q = 1 constant:
//     -> all plots at x 80..159, colour 000; rom_sel = 01 for the whole draw.
//  3. req_c and req_u both high from reset:
//     -> computer drawn first, then user; ack_u occurs exactly one cycle after done.
//     -> repeat with both high again -> the next grant alternates to computer.
//  4. ROM_LAT = 2:
//     -> first plot 2 cycles after the first rom_addr.
//     -> x/y/colour match the address issued 2 cycles earlier.
//  5. reset_n low at pixel 5000 of a draw:
//     -> plot 0 in the same cycle; after release, no plot occurs until a new req.
//  6. CLEAR_ON_RESET_EN defined:
//     -> 19200 plots of 000 after reset; a req_c held high during CLEAR is acked only after CLEAR ends.

Source files
------------

// File: rtl/panel_draw_scheduler.sv
// panel_draw_scheduler: round-robin owner of the vga_adapter plot port for two 80x120 image panels
//
// Two requesters (computer panel, left; user panel, right) each ask for a full
// panel redraw from a 1-bit ROM image. The winner is acked, its image select is
// latched, and one pixel address is issued per clock. x/y/owner travel through a
// ROM_LAT-deep pipeline so that they meet rom_q on the same cycle as plot.
//
// Optional feature: define CLEAR_ON_RESET_EN to sweep the whole 160x120
// framebuffer with colour 000 after every reset before any request is served.
//
// Ports:
//   CLOCK_50, reset_n    clock, asynchronous active-low reset
//   req_c/sel_c, ack_c   computer panel request (level), image select, grant pulse
//   req_u/sel_u, ack_u   user panel request (level), image select, grant pulse
//   busy, done           draw in progress; pulse with the last plot of a panel
//   rom_addr, rom_sel    panel-local ROM address and latched image select
//   rom_q                ROM data, 1 = background, 0 = foreground
//   x, y, colour, plot   vga_adapter pixel write port
module panel_draw_scheduler #(
    parameter int         PANEL_W   = 80,
    parameter int         PANEL_H   = 120,
    parameter int         ROM_LAT   = 1,
    parameter logic [2:0] FG_COLOUR = 3'b010
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        req_c,
    input  logic [1:0]  sel_c,
    input  logic        req_u,
    input  logic [1:0]  sel_u,
    output logic        ack_c,
    output logic        ack_u,
    output logic        busy,
    output logic        done,
    output logic [13:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic        rom_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);
    localparam int          L        = ROM_LAT - 1;
    localparam logic [6:0]  LX_MAX   = 7'(PANEL_W - 1);
    localparam logic [6:0]  LY_MAX   = 7'(PANEL_H - 1);
    localparam logic [7:0]  ORIGIN_U = 8'(PANEL_W);
    localparam logic [13:0] ROW      = 14'(PANEL_W);

    typedef enum logic [2:0] {IDLE, GRANT, SCAN, DRAIN, CLEAR} state_t;

    state_t             state, state_nx;
    logic               owner, prio_u, pick_u, grant_go, scan_last;
    logic               armed, need_clear, clear_last;
    logic [6:0]         lx, ly;
    logic [7:0]         fx;
    logic [ROM_LAT-1:0] pv, pl, po;
    logic [7:0]         px [ROM_LAT];
    logic [6:0]         py [ROM_LAT];

`ifdef CLEAR_ON_RESET_EN
    localparam logic [7:0] CX_MAX = 8'(2 * PANEL_W - 1);
    logic       cleared;
    logic [7:0] cx;
    logic [6:0] cy;
    assign armed      = cleared;
    assign need_clear = ~cleared;
    assign clear_last = (cx == CX_MAX) && (cy == LY_MAX);
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            cleared <= 1'b0;
            cx      <= '0;
            cy      <= '0;
        end else if (state == CLEAR) begin
            cleared <= clear_last;
            cx      <= (cx == CX_MAX) ? '0 : cx + 8'd1;
            cy      <= (cx == CX_MAX) ? ((cy == LY_MAX) ? '0 : cy + 7'd1) : cy;
        end
`else
    // Grants are held off for the first clock after reset release so that a
    // request sitting high during reset never produces an ack while in reset.
    logic live;
    assign armed      = live;
    assign need_clear = 1'b0;
    assign clear_last = 1'b0;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
`endif

    // Tie goes to whichever requester was not granted last; prio_u starts low
    // so the computer wins the first tie after reset.
    assign pick_u    = req_u && (!req_c || prio_u);
    assign grant_go  = (state == IDLE) && armed && (req_c || req_u);
    assign scan_last = (state == SCAN) && (lx == LX_MAX) && (ly == LY_MAX);
    assign rom_addr  = 14'(ly) * ROW + 14'(lx);
    assign fx        = {1'b0, lx} + (owner ? ORIGIN_U : 8'd0);

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = need_clear ? CLEAR : grant_go ? GRANT : IDLE;
            GRANT:   state_nx = SCAN;
            SCAN:    state_nx = scan_last ? DRAIN : SCAN;
            DRAIN:   state_nx = done ? IDLE : DRAIN;
            CLEAR:   state_nx = clear_last ? IDLE : CLEAR;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack_c  = grant_go && !pick_u;
        ack_u  = grant_go && pick_u;
        busy   = state != IDLE;
        plot   = pv[L];
        done   = (state == DRAIN) && pv[L] && pl[L];
        x      = px[L];
        y      = py[L];
        colour = !pv[L] ? 3'b000 : rom_q ? (po[L] ? 3'b000 : 3'b111) : FG_COLOUR;
`ifdef CLEAR_ON_RESET_EN
        plot   = (state == CLEAR) ? 1'b1   : plot;
        x      = (state == CLEAR) ? cx     : x;
        y      = (state == CLEAR) ? cy     : y;
        colour = (state == CLEAR) ? 3'b000 : colour;
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            owner   <= 1'b0;
            prio_u  <= 1'b0;
            rom_sel <= 2'b00;
        end else if (grant_go) begin
            owner   <= pick_u;
            prio_u  <= ~pick_u;
            rom_sel <= pick_u ? sel_u : sel_c;
        end

    // Counters return to 0 after the last address, so every scan starts at (0,0).
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            lx <= '0;
            ly <= '0;
        end else if (state == SCAN) begin
            lx <= (lx == LX_MAX) ? '0 : lx + 7'd1;
            ly <= (lx == LX_MAX) ? ((ly == LY_MAX) ? '0 : ly + 7'd1) : ly;
        end

    // Stage 0 captures the address issued this cycle; the last stage meets rom_q.
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            pv <= '0;
            pl <= '0;
            po <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            pv[0] <= state == SCAN;
            pl[0] <= scan_last;
            po[0] <= owner;
            px[0] <= fx;
            py[0] <= ly;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
                po[i] <= po[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
endmodule
